// File: rtl/tmod_mc_slave_pkg.sv
// ============================================================================
// Module      : tmod_mc_slave_pkg
// Description : Shared types for the multi-channel temperature monitor slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tmod_mc_slave_pkg;

  typedef logic bool_t;

  typedef enum logic [2:0] {
    NOOP   = 3'd0,
    RD_CUR = 3'd1,
    RD_MIN = 3'd2,
    RD_MAX = 3'd3,
    RD_AVG = 3'd4,
    WR_HI  = 3'd5,
    CLR_MM = 3'd6
  } tmod_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } tmod_state_t;

  localparam int unsigned c_CH_W = 4;

endpackage

`default_nettype wire

// File: rtl/tmod_mc_slave_chan.sv
// ============================================================================
// Module      : tmod_chan
// Description : One channel: current/min/max/windowed average and alarm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmod_chan
  import tmod_mc_slave_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int AVG_LOG2   = 2,
  parameter int HYST       = 2,
  parameter int HI_DEFAULT = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] sample,
  input  bool_t            wr_hi,
  input  logic [WIDTH-1:0] hi_data,
  input  bool_t            clr_mm,
  output logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] min_v,
  output logic [WIDTH-1:0] max_v,
  output logic [WIDTH-1:0] avg,
  output logic             alarm
);

  localparam int c_SUM_W = WIDTH + AVG_LOG2;
  localparam int c_CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [WIDTH-1:0]   c_HYST     = WIDTH'(HYST);
  localparam logic [WIDTH-1:0]   c_HI_RST   = WIDTH'(HI_DEFAULT);

  logic [WIDTH-1:0]   r_cur, r_min, r_max, r_avg, r_hi;
  logic [c_SUM_W-1:0] r_sum;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_alarm;

  logic [c_SUM_W-1:0] w_sum_next;
  logic [WIDTH-1:0]   w_clr_lvl;

  assign w_sum_next = r_sum + c_SUM_W'(sample);
  // Clear level saturates at zero so a small threshold never wraps around.
  assign w_clr_lvl  = (r_hi > c_HYST) ? (r_hi - c_HYST) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur   <= '0;
      r_min   <= '1;
      r_max   <= '0;
      r_avg   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_hi    <= c_HI_RST;
      r_alarm <= 1'b0;
    end else begin
      if (tick) begin
        r_cur <= sample;
        if (clr_mm) begin
          r_min <= sample;
          r_max <= sample;
        end else begin
          if (sample < r_min) r_min <= sample;
          if (sample > r_max) r_max <= sample;
        end
        if (r_cnt == c_CNT_LAST) begin
          r_avg <= w_sum_next[AVG_LOG2 +: WIDTH];
          r_sum <= '0;
          r_cnt <= '0;
        end else begin
          r_sum <= w_sum_next;
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (clr_mm) begin
        r_min <= '1;
        r_max <= '0;
      end
      if (wr_hi) r_hi <= hi_data;
      // Alarm looks at the registered sample, so it trails the tick by a cycle.
      if (r_cur >= r_hi) r_alarm <= 1'b1;
      else if (r_cur < w_clr_lvl) r_alarm <= 1'b0;
    end
  end

  assign cur   = r_cur;
  assign min_v = r_min;
  assign max_v = r_max;
  assign avg   = r_avg;
  assign alarm = r_alarm;

endmodule

`default_nettype wire

// File: rtl/tmod_mc_slave.sv
// ============================================================================
// Module      : tmod_mc_slave
// Description : Request FSM and result mux over NUM_CH temperature channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmod_mc_slave
  import tmod_mc_slave_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int AVG_LOG2   = 2,
  parameter int HYST       = 2,
  parameter int HI_DEFAULT = 80
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    tick,
  input  logic [NUM_CH*WIDTH-1:0] temp,
  input  logic                    req_valid,
  input  tmod_op_t                req_op,
  input  logic [c_CH_W-1:0]       req_ch,
  input  logic [WIDTH-1:0]        req_data,
  output logic [WIDTH-1:0]        resp_data,
  output logic                    resp_err,
  output logic                    Done,
  output logic                    busy,
  output logic [NUM_CH-1:0]       alarm
);

  tmod_state_t       r_state;
  tmod_op_t          r_op;
  logic [c_CH_W-1:0] r_ch;
  logic [WIDTH-1:0]  r_data;
  logic [WIDTH-1:0]  r_resp_data;
  logic              r_resp_err;
  logic              r_done;

  logic [WIDTH-1:0]  w_cur [NUM_CH];
  logic [WIDTH-1:0]  w_min [NUM_CH];
  logic [WIDTH-1:0]  w_max [NUM_CH];
  logic [WIDTH-1:0]  w_avg [NUM_CH];
  logic [NUM_CH-1:0] w_wr_hi;
  logic [NUM_CH-1:0] w_clr_mm;
  logic [WIDTH-1:0]  w_stat;
  bool_t             w_ch_ok;

  assign w_ch_ok = ({1'b0, r_ch} < 5'(NUM_CH));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    assign w_wr_hi[c]  = (r_state == EXEC) && (r_op == WR_HI)  && w_ch_ok && (r_ch == 4'(c));
    assign w_clr_mm[c] = (r_state == EXEC) && (r_op == CLR_MM) && w_ch_ok && (r_ch == 4'(c));

    tmod_chan #(
      .WIDTH      (WIDTH),
      .AVG_LOG2   (AVG_LOG2),
      .HYST       (HYST),
      .HI_DEFAULT (HI_DEFAULT)
    ) u_chan (
      .clk     (Clock),
      .rst     (Reset),
      .tick    (tick),
      .sample  (temp[c*WIDTH +: WIDTH]),
      .wr_hi   (w_wr_hi[c]),
      .hi_data (r_data),
      .clr_mm  (w_clr_mm[c]),
      .cur     (w_cur[c]),
      .min_v   (w_min[c]),
      .max_v   (w_max[c]),
      .avg     (w_avg[c]),
      .alarm   (alarm[c])
    );
  end

  // Write ops fall through the case and report zero.
  always_comb begin
    w_stat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_ch == 4'(c)) begin
        case (r_op)
          RD_CUR:  w_stat = w_cur[c];
          RD_MIN:  w_stat = w_min[c];
          RD_MAX:  w_stat = w_max[c];
          RD_AVG:  w_stat = w_avg[c];
          default: w_stat = '0;
        endcase
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_op        <= NOOP;
      r_ch        <= '0;
      r_data      <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && (req_op != NOOP)) begin
            r_op    <= req_op;
            r_ch    <= req_ch;
            r_data  <= req_data;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_resp_data <= w_ch_ok ? w_stat : '1;
          r_resp_err  <= !w_ch_ok;
          r_done      <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          r_resp_data <= '0;
          r_resp_err  <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_data = r_resp_data;
  assign resp_err  = r_resp_err;
  assign Done      = r_done;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tmod_mc_slave.sv
// ============================================================================
// Module      : tb_tmod_mc_slave
// Description : Directed bench with a behavioural model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmod_mc_slave;
  import tmod_mc_slave_pkg::*;

  localparam int NUM_CH = 4, WIDTH = 8, AVG_LOG2 = 2, HYST = 2, HI_DEFAULT = 80;
  localparam int N = 1 << AVG_LOG2;
  localparam int ONES = (1 << WIDTH) - 1;

  logic                    Clock = 1'b0;
  logic                    Reset = 1'b1;
  logic                    tick = 1'b0;
  logic [NUM_CH*WIDTH-1:0] temp = '0;
  logic                    req_valid = 1'b0;
  tmod_op_t                req_op = NOOP;
  logic [3:0]              req_ch = '0;
  logic [WIDTH-1:0]        req_data = '0;
  logic [WIDTH-1:0]        resp_data;
  logic                    resp_err, Done, busy;
  logic [NUM_CH-1:0]       alarm;

  tmod_mc_slave #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2), .HYST(HYST), .HI_DEFAULT(HI_DEFAULT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .tick(tick), .temp(temp),
    .req_valid(req_valid), .req_op(req_op), .req_ch(req_ch), .req_data(req_data),
    .resp_data(resp_data), .resp_err(resp_err), .Done(Done), .busy(busy), .alarm(alarm)
  );

  always #5 Clock = ~Clock;

  int total = 0, bad = 0;

  // Behavioural model state
  int       m_cur[NUM_CH], m_min[NUM_CH], m_max[NUM_CH], m_avg[NUM_CH], m_hi[NUM_CH];
  int       m_wsum[NUM_CH], m_wn[NUM_CH];
  bit       m_alarm[NUM_CH];
  int       m_phase, m_ch, m_data, e_data;
  tmod_op_t m_op;
  bit       e_err, e_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cur[c] = 0; m_min[c] = ONES; m_max[c] = 0; m_avg[c] = 0;
      m_hi[c] = HI_DEFAULT; m_wsum[c] = 0; m_wn[c] = 0; m_alarm[c] = 0;
    end
    m_phase = 0; m_op = NOOP; m_ch = 0; m_data = 0;
    e_data = 0; e_err = 0; e_done = 0;
  endtask

  // Advance the model by one rising edge using the inputs present before it.
  task automatic m_step();
    int  old_phase, clr_ch, s, lvl;
    bit  ex;
    if (Reset) begin m_reset(); return; end
    old_phase = m_phase;
    ex = (old_phase == 1);
    if (old_phase == 2) begin
      m_phase = 0; e_done = 0; e_data = 0; e_err = 0;
    end else if (old_phase == 1) begin
      m_phase = 2; e_done = 1;
      if (m_ch >= NUM_CH) begin e_data = ONES; e_err = 1; end
      else begin
        e_err = 0;
        case (m_op)
          RD_CUR:  e_data = m_cur[m_ch];
          RD_MIN:  e_data = m_min[m_ch];
          RD_MAX:  e_data = m_max[m_ch];
          RD_AVG:  e_data = m_avg[m_ch];
          default: e_data = 0;
        endcase
      end
    end else if (req_valid && req_op != NOOP) begin
      m_phase = 1; m_op = req_op; m_ch = int'(req_ch); m_data = int'(req_data);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      lvl = (m_hi[c] > HYST) ? m_hi[c] - HYST : 0;
      if (m_cur[c] >= m_hi[c]) m_alarm[c] = 1;
      else if (m_cur[c] < lvl) m_alarm[c] = 0;
    end
    clr_ch = (ex && m_op == CLR_MM && m_ch < NUM_CH) ? m_ch : -1;
    if (ex && m_op == WR_HI && m_ch < NUM_CH) m_hi[m_ch] = m_data;
    for (int c = 0; c < NUM_CH; c++) begin
      s = int'(temp[c*WIDTH +: WIDTH]);
      if (tick) begin
        m_cur[c] = s;
        if (c == clr_ch) begin m_min[c] = s; m_max[c] = s; end
        else begin
          if (s < m_min[c]) m_min[c] = s;
          if (s > m_max[c]) m_max[c] = s;
        end
        m_wsum[c] += s; m_wn[c]++;
        if (m_wn[c] == N) begin m_avg[c] = m_wsum[c] / N; m_wsum[c] = 0; m_wn[c] = 0; end
      end else if (c == clr_ch) begin
        m_min[c] = ONES; m_max[c] = 0;
      end
    end
  endtask

  always @(negedge Clock) begin
    chk("done", Done, e_done);
    chk("busy", busy, (m_phase != 0));
    chk("resp_data", resp_data, e_data);
    chk("resp_err", resp_err, e_err);
    for (int c = 0; c < NUM_CH; c++) chk($sformatf("alarm%0d", c), alarm[c], m_alarm[c]);
  end

  task automatic cyc();
    @(posedge Clock);
    m_step();
    @(negedge Clock);
  endtask

  task automatic tick_samples(input int s0, input int s1, input int s2, input int s3);
    temp = {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_req(input tmod_op_t op, input int ch, input int d, input string nm,
                        input int exp_d, input int exp_e);
    int n;
    req_valid = 1'b1; req_op = op; req_ch = 4'(ch); req_data = 8'(d);
    cyc();
    req_valid = 1'b0; req_op = NOOP;
    n = 1;
    while (!Done && n < 10) begin cyc(); n++; end
    chk({nm, "_lat"}, n, 2);
    chk({nm, "_data"}, resp_data, exp_d);
    chk({nm, "_err"}, resp_err, exp_e);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    m_reset();
    cyc(); cyc();
    Reset = 1'b0;

    // Reset state
    chk("alarm_rst", alarm, 0);
    do_req(RD_MIN, 0, 0, "rdmin0_rst", 255, 0);
    do_req(RD_MAX, 0, 0, "rdmax0_rst", 0, 0);

    // Averaging window on ch1
    tick_samples(5, 10, 0, 0);
    tick_samples(5, 20, 0, 0);
    tick_samples(5, 30, 0, 0);
    tick_samples(5, 40, 0, 0);
    do_req(RD_AVG, 1, 0, "rdavg1", 25, 0);
    do_req(RD_MIN, 1, 0, "rdmin1", 10, 0);
    do_req(RD_MAX, 1, 0, "rdmax1", 40, 0);
    do_req(RD_CUR, 1, 0, "rdcur1", 40, 0);

    // Threshold and hysteresis on ch2
    do_req(WR_HI, 2, 50, "wrhi2", 0, 0);
    tick_samples(5, 40, 50, 0); cyc(); chk("alarm2_50", alarm[2], 1);
    tick_samples(5, 40, 49, 0); cyc(); chk("alarm2_49", alarm[2], 1);
    tick_samples(5, 40, 48, 0); cyc(); chk("alarm2_48", alarm[2], 1);
    tick_samples(5, 40, 47, 0); cyc(); chk("alarm2_47", alarm[2], 0);

    // CLR_MM on a tick edge, with a second request held while busy
    dones = 0;
    req_valid = 1'b1; req_op = CLR_MM; req_ch = 4'd0;
    cyc();
    req_op = RD_CUR; req_ch = 4'd1;
    temp = {8'd0, 8'd47, 8'd40, 8'd33}; tick = 1'b1;
    cyc();
    tick = 1'b0;
    dones += int'(Done);
    cyc();
    req_valid = 1'b0; req_op = NOOP;
    dones += int'(Done);
    for (int i = 0; i < 3; i++) begin cyc(); dones += int'(Done); end
    chk("clr_dones", dones, 1);
    do_req(RD_MIN, 0, 0, "rdmin0_clr", 33, 0);
    do_req(RD_MAX, 0, 0, "rdmax0_clr", 33, 0);

    // Out-of-range channel
    do_req(RD_CUR, 7, 0, "rdcur7", 255, 1);
    do_req(CLR_MM, 9, 0, "clr9", 255, 1);
    do_req(RD_MIN, 0, 0, "rdmin0_after_bad", 33, 0);

    // Reset during EXEC
    tick_samples(5, 40, 47, 90); cyc();
    chk("alarm3_pre", alarm[3], 1);
    req_valid = 1'b1; req_op = RD_CUR; req_ch = 4'd3;
    cyc();
    req_valid = 1'b0; req_op = NOOP;
    #2;
    Reset = 1'b1;
    m_reset();
    #1;
    chk("rst_done", Done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_data", resp_data, 0);
    cyc(); cyc();
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin cyc(); dones += int'(Done); end
    chk("rst_no_done", dones, 0);
    do_req(RD_MIN, 0, 0, "rdmin0_rst2", 255, 0);
    do_req(RD_CUR, 3, 0, "rdcur3_rst2", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
